// File: rtl/tableau_dealer.sv
// tableau_dealer: builds a 52-card stride permutation from a seed and deals it
// to the seven Klondike columns. Stock streaming: TABLEAU_DEALER_STOCK_STREAM_EN.
module tableau_dealer #(
    parameter int STRIDE   = 5,
    parameter int NUM_COLS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] seed,
    input  logic       col_ready,
    output logic [2:0] col_sel,
    output logic [2:0] col_cmd,
    output logic [5:0] card_out,
    output logic       stock_valid,
    input  logic       stock_ready,
    output logic [5:0] stock_card,
    output logic       busy,
    output logic       done
);

    // A stride sharing a factor with 52 would revisit cards.
    if (STRIDE < 1 || STRIDE > 51 ||
        (STRIDE % 2) == 0 || (STRIDE % 13) == 0) begin : g_bad_stride
        $error("tableau_dealer: STRIDE must be 1..51, coprime to 52");
    end

    if (NUM_COLS != 7) begin : g_bad_cols
        $error("tableau_dealer: NUM_COLS must be 7");
    end

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOAD       = 3'd1;
    localparam logic [2:0] DEAL_TAB   = 3'd2;
    localparam logic [2:0] DONE       = 3'd4;
`ifdef TABLEAU_DEALER_STOCK_STREAM_EN
    localparam logic [2:0] DEAL_STOCK = 3'd3;
    localparam logic [2:0] TAB_EXIT   = DEAL_STOCK;
`else
    localparam logic [2:0] TAB_EXIT   = DONE;
`endif

    logic [2:0] state;
    logic [5:0] idx;
    logic [5:0] k;
    logic [2:0] r;
    logic [2:0] c;

    logic [5:0] seed_mod;
    logic [6:0] idx_sum;
    logic [5:0] idx_next;
    logic [5:0] card_now;
    logic       in_tab;

    // Suit by compare-subtract against 39/26/13; rank is the remainder + 1.
    function automatic logic [5:0] map_card(input logic [5:0] i);
        logic [1:0] suit;
        logic [3:0] rem;
        if (i >= 6'd39) begin
            suit = 2'd3;
            rem  = 4'(i - 6'd39);
        end else if (i >= 6'd26) begin
            suit = 2'd2;
            rem  = 4'(i - 6'd26);
        end else if (i >= 6'd13) begin
            suit = 2'd1;
            rem  = 4'(i - 6'd13);
        end else begin
            suit = 2'd0;
            rem  = 4'(i);
        end
        map_card = {suit, rem + 4'd1};
    endfunction

    assign seed_mod = (seed >= 6'd52) ? seed - 6'd52 : seed;
    assign idx_sum  = {1'b0, idx} + 7'(STRIDE);
    assign idx_next = (idx_sum >= 7'd52) ? 6'(idx_sum - 7'd52)
                                         : idx_sum[5:0];
    assign card_now = map_card(idx);
    assign in_tab   = (state == DEAL_TAB);

    // Deal sequencer: permutation index, card count and Klondike round/column.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            k     <= '0;
            r     <= '0;
            c     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        idx   <= seed_mod;
                        k     <= '0;
                        r     <= '0;
                        c     <= '0;
                    end
                end
                LOAD: state <= DEAL_TAB;
                DEAL_TAB: begin
                    if (col_ready) begin
                        k   <= k + 6'd1;
                        idx <= idx_next;
                        if (c == 3'd6) begin
                            r <= r + 3'd1;
                            c <= r + 3'd1;
                        end else begin
                            c <= c + 3'd1;
                        end
                        if (k == 6'd27) state <= TAB_EXIT;
                    end
                end
`ifdef TABLEAU_DEALER_STOCK_STREAM_EN
                DEAL_STOCK: begin
                    if (stock_ready) begin
                        k   <= k + 6'd1;
                        idx <= idx_next;
                        if (k == 6'd51) state <= DONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Column push port: only ever push (010) or idle, never pop.
    always_comb begin
        col_cmd  = in_tab ? 3'b010 : 3'b000;
        col_sel  = in_tab ? c : 3'd0;
        card_out = in_tab ? card_now : 6'h3f;
        busy     = (state == LOAD) || (state == DEAL_TAB);
`ifdef TABLEAU_DEALER_STOCK_STREAM_EN
        busy     = busy || (state == DEAL_STOCK);
`endif
        done     = (state == DONE);
    end

`ifdef TABLEAU_DEALER_STOCK_STREAM_EN
    // Stock port presents the current leftover card until it is taken.
    always_comb begin
        stock_valid = (state == DEAL_STOCK);
        stock_card  = stock_valid ? card_now : 6'h3f;
    end
`else
    logic unused_stock_ready;
    assign unused_stock_ready = stock_ready;

    // Stock port is inert when streaming is not built in.
    always_comb begin
        stock_valid = 1'b0;
        stock_card  = 6'h3f;
    end
`endif

endmodule
